// File: rtl/prog_sequencer.sv
// Fetch-path program counter: multi-phase stepping, jump/call/ret with a return-address stack, sticky stack errors.
// All updates land one cycle after the edge; stall freezes every piece of state.
module prog_sequencer #(
    parameter  int ADDR_W      = 16,
    parameter  int PHASES      = 2,
    parameter  int STACK_DEPTH = 8,
    localparam int PHASE_W     = (PHASES > 1) ? $clog2(PHASES) : 1,
    localparam int LVL_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic [ADDR_W-1:0] target,
    input  logic              clear_err,
    output logic [ADDR_W-1:0] addr,
    output logic [PHASE_W-1:0] phase,
    output logic              execute_flag,
    output logic [LVL_W-1:0]  stack_level,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              err_overflow,
    output logic              err_underflow
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0]  stack_d [STACK_DEPTH];

    logic [ADDR_W-1:0]  seq_addr;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;
    logic               full;
    logic               empty;
    logic               exec;

    assign seq_addr = addr_q + ADDR_W'(1);
    assign push_idx = IDX_W'(level_q);
    assign pop_idx  = IDX_W'(level_q - LVL_W'(1));
    assign full     = (level_q == LVL_W'(STACK_DEPTH));
    assign empty    = (level_q == '0);
    assign exec     = (phase_q == PHASE_W'(PHASES - 1));

    always_comb begin
        addr_d  = addr_q;
        phase_d = phase_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;
        if (!stall) begin
            if (clear_err) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            if (!exec) begin
                phase_d = phase_q + PHASE_W'(1);
            end else begin
                // Execute phase: default is the sequential step; rejected call/ret fall back to it.
                phase_d = '0;
                addr_d  = seq_addr;
                if (ret_en) begin
                    if (!empty) begin
                        addr_d  = stack_q[pop_idx];
                        level_d = level_q - LVL_W'(1);
                    end else begin
                        unf_d = 1'b1;
                    end
                end else if (call_en) begin
                    if (!full) begin
                        stack_d[push_idx] = seq_addr;
                        addr_d            = target;
                        level_d           = level_q + LVL_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (jump_en) begin
                    addr_d = target;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            phase_q <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            addr_q  <= addr_d;
            phase_q <= phase_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            stack_q <= stack_d;
        end
    end

    assign addr          = addr_q;
    assign phase         = phase_q;
    assign execute_flag  = exec;
    assign stack_level   = level_q;
    assign stack_full    = full;
    assign stack_empty   = empty;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: two instances (PHASES=2/DEPTH=8 and PHASES=3/DEPTH=2).
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, jump_en, call_en, ret_en, clear_err;
    logic [15:0] target;

    logic [15:0] u0_addr, u1_addr;
    logic [0:0]  u0_phase;
    logic [1:0]  u1_phase;
    logic        u0_exec, u1_exec;
    logic [3:0]  u0_lvl;
    logic [1:0]  u1_lvl;
    logic        u0_full, u1_full, u0_empty, u1_empty;
    logic        u0_ovf, u1_ovf, u0_unf, u1_unf;

    prog_sequencer #(.ADDR_W(16), .PHASES(2), .STACK_DEPTH(8)) u0 (
        .clk(clk), .reset(reset), .stall(stall), .jump_en(jump_en), .call_en(call_en),
        .ret_en(ret_en), .target(target), .clear_err(clear_err),
        .addr(u0_addr), .phase(u0_phase), .execute_flag(u0_exec), .stack_level(u0_lvl),
        .stack_full(u0_full), .stack_empty(u0_empty),
        .err_overflow(u0_ovf), .err_underflow(u0_unf)
    );

    prog_sequencer #(.ADDR_W(16), .PHASES(3), .STACK_DEPTH(2)) u1 (
        .clk(clk), .reset(reset), .stall(stall), .jump_en(jump_en), .call_en(call_en),
        .ret_en(ret_en), .target(target), .clear_err(clear_err),
        .addr(u1_addr), .phase(u1_phase), .execute_flag(u1_exec), .stack_level(u1_lvl),
        .stack_full(u1_full), .stack_empty(u1_empty),
        .err_overflow(u1_ovf), .err_underflow(u1_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    d;
        string tag;
        int    a;
        int    ph;
        int    lvl;
        bit    ovf;
        bit    unf;
    } exp_t;

    exp_t  q[$];
    event  mon_ev;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    sel      = 0;
    string tag      = "reset";

    // Regular sample point: just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        -> mon_ev;
    end

    initial forever begin
        exp_t e;
        int   aa, ap, al, depth, nph;
        bit   ax, af, ae, ao, au, ex, ok;
        @(mon_ev);
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.d == 0) begin
                aa = int'(u0_addr); ap = int'(u0_phase); al = int'(u0_lvl);
                ax = u0_exec; af = u0_full; ae = u0_empty; ao = u0_ovf; au = u0_unf;
                depth = 8; nph = 2;
            end else begin
                aa = int'(u1_addr); ap = int'(u1_phase); al = int'(u1_lvl);
                ax = u1_exec; af = u1_full; ae = u1_empty; ao = u1_ovf; au = u1_unf;
                depth = 2; nph = 3;
            end
            ex = (e.ph == nph - 1);
            ok = (aa == e.a) && (ap == e.ph) && (al == e.lvl) && (ax == ex) &&
                 (af == (e.lvl == depth)) && (ae == (e.lvl == 0)) &&
                 (ao == e.ovf) && (au == e.unf);
            n_checks++;
            if (ok) n_pass++;
            else $display("FAIL %s dut%0d: got addr=%h ph=%0d exec=%0d lvl=%0d full=%0d empty=%0d ovf=%0d unf=%0d; want addr=%h ph=%0d exec=%0d lvl=%0d full=%0d empty=%0d ovf=%0d unf=%0d",
                          e.tag, e.d, aa, ap, ax, al, af, ae, ao, au,
                          e.a, e.ph, ex, e.lvl, (e.lvl == depth), (e.lvl == 0), e.ovf, e.unf);
        end
    end

    task automatic push_exp(input int a, input int ph, input int lvl, input bit ovf, input bit unf);
        exp_t e;
        e.d = sel; e.tag = tag; e.a = a; e.ph = ph; e.lvl = lvl; e.ovf = ovf; e.unf = unf;
        q.push_back(e);
    endtask

    // One cycle: drive controls at the falling edge, expect the state after the next rising edge.
    task automatic cyc(input bit st, input bit j, input bit c, input bit r, input bit ce,
                       input logic [15:0] tg,
                       input int a, input int ph, input int lvl, input bit ovf, input bit unf);
        @(negedge clk);
        reset = 1'b0; stall = st; jump_en = j; call_en = c; ret_en = r; clear_err = ce; target = tg;
        push_exp(a, ph, lvl, ovf, unf);
    endtask

    task automatic step(input int a, input int ph, input int lvl, input bit ovf, input bit unf);
        cyc(0, 0, 0, 0, 0, 16'h0000, a, ph, lvl, ovf, unf);
    endtask

    task automatic rst_cyc();
        @(negedge clk);
        reset = 1'b1; stall = 0; jump_en = 0; call_en = 0; ret_en = 0; clear_err = 0; target = 0;
        push_exp(0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; stall = 0; jump_en = 0; call_en = 0; ret_en = 0; clear_err = 0; target = 0;

        // PHASES=2, DEPTH=8
        sel = 0;
        tag = "reset";      rst_cyc();
        tag = "freerun";    step(0, 1, 0, 0, 0);
                            step(1, 0, 0, 0, 0);
                            step(1, 1, 0, 0, 0);
                            step(2, 0, 0, 0, 0);
        tag = "jump_ph0";   cyc(0, 1, 0, 0, 0, 16'h1234, 2, 1, 0, 0, 0);
        tag = "jump_exec";  cyc(0, 1, 0, 0, 0, 16'h1234, 16'h1234, 0, 0, 0, 0);
                            step(16'h1234, 1, 0, 0, 0);
        tag = "stall";      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 16'h0010, 16'h1234, 1, 0, 0, 0);
        tag = "unstall";    cyc(0, 1, 0, 0, 0, 16'h0010, 16'h0010, 0, 0, 0, 0);
                            step(16'h0010, 1, 0, 0, 0);
        tag = "call";       cyc(0, 0, 1, 0, 0, 16'h0200, 16'h0200, 0, 1, 0, 0);
                            step(16'h0200, 1, 1, 0, 0);
        tag = "ret";        cyc(0, 0, 0, 1, 0, 16'h0000, 16'h0011, 0, 0, 0, 0);
                            step(16'h0011, 1, 0, 0, 0);
        tag = "nest";       cyc(0, 0, 1, 0, 0, 16'h0100, 16'h0100, 0, 1, 0, 0);
                            step(16'h0100, 1, 1, 0, 0);
                            cyc(0, 0, 1, 0, 0, 16'h0200, 16'h0200, 0, 2, 0, 0);
                            step(16'h0200, 1, 2, 0, 0);
                            cyc(0, 0, 1, 0, 0, 16'h0ABC, 16'h0ABC, 0, 3, 0, 0);
                            step(16'h0ABC, 1, 3, 0, 0);
        tag = "call_gt_jmp"; cyc(0, 1, 1, 0, 0, 16'h0300, 16'h0300, 0, 4, 0, 0);
                            step(16'h0300, 1, 4, 0, 0);
        tag = "ret_gt_all"; cyc(0, 1, 1, 1, 0, 16'h0555, 16'h0ABD, 0, 3, 0, 0);
                            step(16'h0ABD, 1, 3, 0, 0);
        tag = "jump_lvl3";  cyc(0, 1, 0, 0, 0, 16'h0ABC, 16'h0ABC, 0, 3, 0, 0);

        // Asynchronous reset between edges must clear outputs without a clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1; jump_en = 0; call_en = 0; ret_en = 0;
        #1;
        tag = "async_rst";  push_exp(0, 0, 0, 0, 0);
        -> mon_ev;
        tag = "restart";    step(0, 1, 0, 0, 0);
        tag = "unf_setwins"; cyc(0, 0, 0, 1, 1, 16'h0000, 1, 0, 0, 0, 1);
        tag = "clr_stalled"; cyc(1, 0, 0, 0, 1, 16'h0000, 1, 0, 0, 0, 1);
        tag = "clr_err";    cyc(0, 0, 0, 0, 1, 16'h0000, 1, 1, 0, 0, 0);

        // PHASES=3, DEPTH=2
        sel = 1;
        tag = "reset3";     rst_cyc();
        tag = "freerun3";   step(0, 1, 0, 0, 0);
                            step(0, 2, 0, 0, 0);
        tag = "jump_ffff";  cyc(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
                            step(16'hFFFF, 1, 0, 0, 0);
                            step(16'hFFFF, 2, 0, 0, 0);
        tag = "wrap";       step(0, 0, 0, 0, 0);
                            step(0, 1, 0, 0, 0);
                            step(0, 2, 0, 0, 0);
                            cyc(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
                            step(16'hFFFF, 1, 0, 0, 0);
                            step(16'hFFFF, 2, 0, 0, 0);
        tag = "call_ffff";  cyc(0, 0, 1, 0, 0, 16'h0040, 16'h0040, 0, 1, 0, 0);
                            step(16'h0040, 1, 1, 0, 0);
                            step(16'h0040, 2, 1, 0, 0);
        tag = "call_full";  cyc(0, 0, 1, 0, 0, 16'h0080, 16'h0080, 0, 2, 0, 0);
                            step(16'h0080, 1, 2, 0, 0);
                            step(16'h0080, 2, 2, 0, 0);
        tag = "overflow";   cyc(0, 0, 1, 0, 0, 16'h00C0, 16'h0081, 0, 2, 1, 0);
                            step(16'h0081, 1, 2, 1, 0);
                            step(16'h0081, 2, 2, 1, 0);
        tag = "ret_41";     cyc(0, 0, 0, 1, 0, 16'h0000, 16'h0041, 0, 1, 1, 0);
                            step(16'h0041, 1, 1, 1, 0);
                            step(16'h0041, 2, 1, 1, 0);
        tag = "ret_0000";   cyc(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
                            step(0, 1, 0, 1, 0);
                            step(0, 2, 0, 1, 0);
        tag = "underflow";  cyc(0, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 1, 1);
        tag = "clr_both";   cyc(0, 0, 0, 0, 1, 16'h0000, 1, 1, 0, 0, 0);

        @(negedge clk);
        clear_err = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
